// File: rtl/cfg_lutn_pipe.sv
// N-input look-up table with a serially reloadable truth table and an optional
// output pipeline; a small IDLE/LOAD/COMMIT FSM swaps the table atomically.
module cfg_lutn_pipe #(
  parameter int              N         = 3,
  parameter logic [2**N-1:0] INIT      = 8'hAB,
  parameter int              PIPE      = 1,
  parameter bit              MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] I,
  output logic         O,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_bit,
  input  logic         cfg_abort,
  output logic         cfg_busy,
  output logic         cfg_done,
  output logic [1:0]   cfg_state
);
  localparam int L = 2**N;
  localparam logic [N:0] LAST = (N+1)'(L-1);

  // Handshake: a bit is accepted on a rising edge where cfg_valid && cfg_ready
  // and cfg_abort is low; cfg_ready is low only during the one COMMIT cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2} state_t;

  state_t       state, state_nx;
  logic [L-1:0] lut_q, shadow, shifted;
  logic [N:0]   count;
  logic         accept, raw;

  assign shifted   = MSB_FIRST ? {shadow[L-2:0], cfg_bit} : {cfg_bit, shadow[L-1:1]};
  assign raw       = lut_q[I];
  assign cfg_state = state;

  always_comb begin
    state_nx  = state;
    cfg_ready = (state != COMMIT);
    cfg_busy  = (state != IDLE);
    cfg_done  = (state == COMMIT) && !rst;
    accept    = cfg_valid && (state != COMMIT) && !cfg_abort;
    case (state)
      IDLE:   if (accept) state_nx = LOAD;
      LOAD: begin
        if (cfg_abort)                    state_nx = IDLE;
        else if (accept && count == LAST) state_nx = COMMIT;
      end
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lut_q  <= INIT;
      shadow <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      if (state == COMMIT) begin
        lut_q <= shadow;
        count <= '0;
      end else if (cfg_abort) begin
        shadow <= '0;
        count  <= '0;
      end else if (accept) begin
        shadow <= shifted;
        count  <= (state == IDLE) ? (N+1)'(1) : count + (N+1)'(1);
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_comb
      assign O = raw;
    end else begin : g_pipe
      logic [PIPE-1:0] stage;
      always_ff @(posedge clk) begin
        if (rst) begin
          stage <= '0;
        end else begin
          stage[0] <= raw;
          for (int k = 1; k < PIPE; k++) stage[k] <= stage[k-1];
        end
      end
      assign O = stage[PIPE-1];
    end
  endgenerate
endmodule

// File: tb/tb_cfg_lutn_pipe.sv
// Directed bench for cfg_lutn_pipe: default instance (N=3, PIPE=1, MSB first)
// and a second instance with N=4, PIPE=0, LSB first, INIT=16'h8001.
module tb_cfg_lutn_pipe;
  logic       clk = 0;
  logic       rst;
  logic [2:0] i1;
  logic       o1, valid1, ready1, bit1, abort1, busy1, done1;
  logic [1:0] state1;
  logic [3:0] i2;
  logic       o2, valid2, ready2, bit2, abort2, busy2, done2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;
  int done_cnt1 = 0;
  int done_cnt2 = 0;
  int base;

  logic [7:0]  ab = 8'hAB;
  logic [7:0]  f0 = 8'hF0;
  logic [7:0]  p55 = 8'h55;
  logic [15:0] i8001 = 16'h8001;

  always #5 clk = ~clk;

  cfg_lutn_pipe dut1 (
    .clk(clk), .rst(rst), .I(i1), .O(o1),
    .cfg_valid(valid1), .cfg_ready(ready1), .cfg_bit(bit1), .cfg_abort(abort1),
    .cfg_busy(busy1), .cfg_done(done1), .cfg_state(state1)
  );

  cfg_lutn_pipe #(.N(4), .INIT(16'h8001), .PIPE(0), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .I(i2), .O(o2),
    .cfg_valid(valid2), .cfg_ready(ready2), .cfg_bit(bit2), .cfg_abort(abort2),
    .cfg_busy(busy2), .cfg_done(done2), .cfg_state(state2)
  );

  always @(posedge clk) begin
    if (done1) done_cnt1++;
    if (done2) done_cnt2++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send1(input logic b);
    valid1 = 1; bit1 = b;
    tick();
    valid1 = 0;
  endtask

  task automatic send2(input logic b);
    valid2 = 1; bit2 = b;
    tick();
    valid2 = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    int c8, sent;
    logic v;
    rst = 1; i1 = 0; valid1 = 0; bit1 = 0; abort1 = 0;
    i2 = 0; valid2 = 0; bit2 = 0; abort2 = 0;

    // Reset values and pipelined lookup of INIT
    do_reset();
    check("rst_o", o1, 0);
    check("rst_ready", ready1, 1);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    i1 = 0; tick(); check("lut_i0", o1, 1);
    i1 = 1; tick(); check("lut_i1", o1, 1);
    i1 = 7; tick(); check("lut_i7", o1, 1);
    i1 = 2; tick(); check("lut_i2", o1, 0);
    i1 = 4; tick(); check("lut_i4", o1, 0);

    // Serial load of 8'h55, MSB first
    base = done_cnt1;
    send1(0);
    check("load_busy_first", busy1, 1);
    check("load_ready", ready1, 1);
    for (int k = 6; k >= 0; k--) begin
      send1(p55[k]);
      if (k == 1) check("load_no_done_early", done1, 0);
    end
    check("commit_done", done1, 1);
    check("commit_ready", ready1, 0);
    check("commit_busy", busy1, 1);
    i1 = 0; tick();
    check("after_commit_done", done1, 0);
    check("after_commit_busy", busy1, 0);
    check("done_once_55", done_cnt1 - base, 1);
    check("new_i0", o1, 1);
    i1 = 1; tick(); check("new_i1", o1, 0);

    // Lookup sweep while loading 8'h00 with valid gaps
    do_reset();
    c8 = 1000; sent = 0;
    for (int c = 0; c < 20; c++) begin
      i1 = c[2:0];
      v = (sent < 8) && (c % 3 != 2);
      valid1 = v; bit1 = 0;
      tick();
      valid1 = 0;
      if (v) begin
        sent++;
        if (sent == 8) c8 = c;
      end
      check("sweep", o1, (c > c8 + 1) ? 1'b0 : ab[c % 8]);
    end

    // Abort with simultaneous valid, then a full load of 8'hF0
    do_reset();
    base = done_cnt1;
    for (int k = 0; k < 5; k++) send1(1);
    abort1 = 1; valid1 = 1; bit1 = 1;
    tick();
    abort1 = 0; valid1 = 0;
    check("abort_state", state1, 0);
    check("abort_busy", busy1, 0);
    i1 = 7; tick(); check("abort_tab_i7", o1, 1);
    i1 = 2; tick(); check("abort_tab_i2", o1, 0);
    check("abort_no_done", done_cnt1 - base, 0);
    for (int k = 7; k >= 0; k--) send1(f0[k]);
    check("f0_done", done1, 1);
    tick();
    check("f0_done_once", done_cnt1 - base, 1);
    i1 = 4; tick(); check("f0_i4", o1, 1);
    i1 = 3; tick(); check("f0_i3", o1, 0);
    i1 = 7; tick(); check("f0_i7", o1, 1);
    i1 = 0; tick(); check("f0_i0", o1, 0);

    // Reset in the middle of a load, with a bit offered on the reset edge
    base = done_cnt1;
    for (int k = 0; k < 4; k++) send1(0);
    rst = 1; valid1 = 1; bit1 = 0;
    tick();
    rst = 0; valid1 = 0;
    check("midrst_ready", ready1, 1);
    check("midrst_busy", busy1, 0);
    check("midrst_state", state1, 0);
    i1 = 1; tick(); check("midrst_tab_i1", o1, 1);
    for (int k = 0; k < 7; k++) send1(0);
    check("midrst_cnt_7", done1, 0);
    send1(0);
    check("midrst_cnt_8", done1, 1);
    // Reset landing on the COMMIT cycle: no pulse, table back to INIT
    rst = 1; #1;
    check("rst_commit_done", done1, 0);
    tick();
    rst = 0;
    check("midrst_no_done", done_cnt1 - base, 0);
    i1 = 0; tick(); check("rst_commit_tab_i0", o1, 1);

    // Second instance: combinational, LSB first
    for (int k = 0; k < 16; k++) begin
      i2 = 4'(k); #1;
      check("n4_init", o2, i8001[k]);
    end
    base = done_cnt2;
    send2(1);
    for (int k = 0; k < 15; k++) send2(0);
    check("n4_done", done2, 1);
    i2 = 15; #1;
    check("n4_commit_old_i15", o2, 1);
    tick();
    check("n4_done_once", done_cnt2 - base, 1);
    for (int k = 0; k < 16; k++) begin
      i2 = 4'(k); #1;
      check("n4_new", o2, (k == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
